// File: rtl/fp_scoreboard.sv
// fp_scoreboard: in-order checker comparing FP unit results against queued expectations.
// Expected entries sit in a circular FIFO; each dut_ready pops the head and compares.
// Optional first-failure capture is built only when FP_SCOREBOARD_CAPTURE_EN is defined.

module fp_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exp_valid,
  output logic            exp_ready,
  input  logic [XLEN-1:0] exp_result,
  input  logic [4:0]      exp_flags,
  input  logic            exp_nanmask,
  input  logic            exp_last,
  input  logic            dut_ready,
  input  logic [XLEN-1:0] dut_result,
  input  logic [4:0]      dut_flags,
  output logic            fail,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [31:0]     cmp_count,
  output logic            underflow,
  output logic [XLEN-1:0] fail_exp_result,
  output logic [XLEN-1:0] fail_dut_result,
  output logic [4:0]      fail_exp_flags,
  output logic [4:0]      fail_dut_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  // Canonical quiet NaN; its set bits are exactly the exponent plus quiet bit,
  // so the same pattern doubles as the relaxed-compare mask.
  localparam logic [63:0] CanonNan64 = (XLEN == 64) ? 64'h7FF8_0000_0000_0000
                                                    : 64'h0000_0000_7FC0_0000;
  localparam logic [XLEN-1:0] CanonNan = CanonNan64[XLEN-1:0];
  localparam logic [XLEN-1:0] NanMask  = CanonNan64[XLEN-1:0];

  // FIFO storage (data only, no reset needed)
  logic [XLEN-1:0] mem_result  [DEPTH];
  logic [4:0]      mem_flags   [DEPTH];
  logic            mem_nanmask [DEPTH];
  logic            mem_last    [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic        fail_q, fail_d;
  logic        done_q, done_d;
  logic        underflow_q, underflow_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] cmp_count_q, cmp_count_d;

  logic empty, full, push, pop, uf_event;
  logic [XLEN-1:0] head_result;
  logic [4:0]      head_flags;
  logic            head_nanmask, head_last;
  logic            nan_relax, mismatch;
  logic [XLEN-1:0] diff;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Held high while in reset so upstream never sees a stall before pointers clear.
  assign exp_ready = ~full | ~reset;

  // Push while full is dropped even if a pop frees a slot this cycle; no empty bypass.
  assign push     = exp_valid & ~full;
  assign pop      = dut_ready & ~empty;
  assign uf_event = dut_ready & empty;

  assign head_result  = mem_result[rd_ptr_q[AW-1:0]];
  assign head_flags   = mem_flags[rd_ptr_q[AW-1:0]];
  assign head_nanmask = mem_nanmask[rd_ptr_q[AW-1:0]];
  assign head_last    = mem_last[rd_ptr_q[AW-1:0]];

  assign nan_relax = head_nanmask & (dut_result == CanonNan);
  assign diff      = (dut_result ^ head_result) & (nan_relax ? NanMask : {XLEN{1'b1}});
  assign mismatch  = (|diff) | (dut_flags != head_flags);

  // Write incoming expected entries into the FIFO
  always_ff @(posedge clock) begin
    if (push) begin
      mem_result[wr_ptr_q[AW-1:0]]  <= exp_result;
      mem_flags[wr_ptr_q[AW-1:0]]   <= exp_flags;
      mem_nanmask[wr_ptr_q[AW-1:0]] <= exp_nanmask;
      mem_last[wr_ptr_q[AW-1:0]]    <= exp_last;
    end
  end

  // Next-state for pointers, counters and sticky status
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fail_d      = fail_q;
    done_d      = done_q;
    underflow_d = underflow_q;
    err_count_d = err_count_q;
    cmp_count_d = cmp_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PtrOne;
      cmp_count_d = cmp_count_q + 32'd1;
      if (mismatch) begin
        fail_d      = 1'b1;
        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
      end
      if (head_last) begin
        done_d = 1'b1;
      end
    end

    if (uf_event) begin
      underflow_d = 1'b1;
      fail_d      = 1'b1;
      err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      err_count_q <= '0;
      cmp_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      err_count_q <= err_count_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  assign fail      = fail_q;
  assign done      = done_q;
  assign pass      = done_q & ~fail_q;
  assign underflow = underflow_q;
  assign err_count = err_count_q;
  assign cmp_count = cmp_count_q;

`ifdef FP_SCOREBOARD_CAPTURE_EN
  logic            cap_valid_q;
  logic [XLEN-1:0] cap_exp_result_q, cap_dut_result_q;
  logic [4:0]      cap_exp_flags_q, cap_dut_flags_q;

  // Latch the first compare mismatch, then hold until reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cap_valid_q      <= 1'b0;
      cap_exp_result_q <= '0;
      cap_dut_result_q <= '0;
      cap_exp_flags_q  <= '0;
      cap_dut_flags_q  <= '0;
    end else if (pop && mismatch && !cap_valid_q) begin
      cap_valid_q      <= 1'b1;
      cap_exp_result_q <= head_result;
      cap_dut_result_q <= dut_result;
      cap_exp_flags_q  <= head_flags;
      cap_dut_flags_q  <= dut_flags;
    end
  end

  assign fail_exp_result = cap_exp_result_q;
  assign fail_dut_result = cap_dut_result_q;
  assign fail_exp_flags  = cap_exp_flags_q;
  assign fail_dut_flags  = cap_dut_flags_q;
`else
  assign fail_exp_result = '0;
  assign fail_dut_result = '0;
  assign fail_exp_flags  = '0;
  assign fail_dut_flags  = '0;
`endif

endmodule
